// File: rtl/debug_hex_pkg.sv
// debug_hex_pkg
//   Shared constants and helpers for the paged seven-segment debug display.
//   - SEG_BLANK : segment pattern {g,f,e,d,c,b,a} with every segment off.
//   - SEG_TABLE : active-low segment patterns for hex nibbles 0..F.
//   - seg_of()  : nibble to segment pattern lookup.
//   - idx_w()   : bit width needed to index n items (at least 1).
package debug_hex_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index 0..15 -> {g,f,e,d,c,b,a}, 0 = segment lit.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] seg_of(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debug_hex_debounce.sv
// debug_hex_debounce
//   Two-flop synchronizer, level debouncer and press-pulse generator for an
//   active-low board key.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   key_n    in   raw active-low key, asynchronous to clk
//   press    out  one-cycle pulse on each accepted key press (debounced 1->0)
module debug_hex_debounce
   import debug_hex_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic press
);

   localparam int            CW       = idx_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          key_db;
   logic [CW-1:0] cnt;
   logic [1:0]    fill;
   logic          armed;
   logic          accept;

   // The counter tracks how many consecutive cycles the synced key has
   // disagreed with the accepted level; the new level is taken on the last one.
   assign accept = (sync_p1 != key_db) && (cnt == CNT_LAST);

   // A press only counts once the key has been seen released after reset, so a
   // key held through reset release cannot step the page.
   assign press  = accept && !sync_p1 && armed;

   // Stage p0 -> p1: synchronizer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= key_n;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_db <= 1'b1;
         cnt    <= '0;
         fill   <= 2'd0;
         armed  <= 1'b0;
      end else begin
         // fill reaches 2 once the synchronizer holds real samples, not reset values
         if (fill != 2'd2)
            fill <= fill + 2'd1;
         if (fill == 2'd2 && sync_p1 && key_db)
            armed <= 1'b1;

         if (sync_p1 == key_db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            key_db <= sync_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/debug_hex_pager.sv
// debug_hex_pager
//   Paged seven-segment debug display. NUM_PAGES pages of NUM_DIGITS nibbles
//   are shown one page at a time; a debounced key press steps the page and a
//   freeze switch displays a snapshot of all pages taken on its rising edge.
//   While frozen, the page-marker decimal point blinks.
// Build option:
//   DEBUG_HEX_LZB_EN  when defined, leading zeros of the shown page are blanked
//                     (digit 0 always shown).
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   page_data  in   page p digit d at [(p*NUM_DIGITS+d)*4 +: 4], digit 0 rightmost
//   btn_n      in   raw active-low page key, asynchronous
//   freeze     in   raw freeze switch, asynchronous, 1 = show snapshot
//   hex_n      out  digit d at [d*8 +: 8] = {dp,g,f,e,d,c,b,a}, active-low
//   page_idx   out  page currently displayed
module debug_hex_pager
   import debug_hex_pkg::*;
#(
   parameter int NUM_DIGITS      = 6,
   parameter int NUM_PAGES       = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_CYCLES    = 25000000
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
   input  logic                              btn_n,
   input  logic                              freeze,
   output logic [NUM_DIGITS*8-1:0]           hex_n,
   output logic [idx_w(NUM_PAGES)-1:0]       page_idx
);

   localparam int            PAGE_W     = NUM_DIGITS * 4;
   localparam int            DW         = NUM_PAGES * PAGE_W;
   localparam int            PW         = idx_w(NUM_PAGES);
   localparam int            BW         = idx_w(BLINK_CYCLES);
   localparam logic [PW-1:0] PAGE_LAST  = PW'(NUM_PAGES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic                    press;
   logic                    fz_p0;
   logic                    fz_p1;
   logic                    fz_state;
   logic                    fz_rise;
   logic                    use_snap;
   logic [DW-1:0]           snap;
   logic [DW-1:0]           src;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_ph;
   logic [PAGE_W-1:0]       page_nib;
   logic [3:0]              nib;
   logic [6:0]              seg;
   logic [NUM_DIGITS*8-1:0] hex_nxt;
`ifdef DEBUG_HEX_LZB_EN
   logic                    lead;
`endif

   debug_hex_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (btn_n),
      .press   (press)
   );

   assign fz_rise  = fz_p1 & ~fz_state;
   // In the capture cycle the snapshot register is still stale, so live data
   // (which is exactly what is being captured) is shown instead.
   assign use_snap = fz_p1 & fz_state;
   assign src      = use_snap ? snap : page_data;

   // Stage p0 -> p1: freeze synchronizer, then edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fz_p0    <= 1'b0;
         fz_p1    <= 1'b0;
         fz_state <= 1'b0;
         snap     <= '0;
      end else begin
         fz_p0    <= freeze;
         fz_p1    <= fz_p0;
         fz_state <= fz_p1;
         if (fz_rise)
            snap <= page_data;
      end
   end

   // Blink phase runs only while frozen; unfrozen it parks lit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
      end else if (!fz_p1) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink_ph  <= ~blink_ph;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         page_idx <= '0;
      else if (press)
         page_idx <= (page_idx == PAGE_LAST) ? '0 : page_idx + PW'(1);
   end

   always_comb begin
      page_nib = '0;
      nib      = '0;
      seg      = SEG_BLANK;
      hex_nxt  = '1;
`ifdef DEBUG_HEX_LZB_EN
      lead     = 1'b1;
`endif
      for (int p = 0; p < NUM_PAGES; p++) begin
         if (page_idx == PW'(p))
            page_nib = src[p*PAGE_W +: PAGE_W];
      end
      // Walk from the leftmost digit so leading zeros can be tracked.
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         nib = page_nib[d*4 +: 4];
         seg = seg_of(nib);
`ifdef DEBUG_HEX_LZB_EN
         if (nib != 4'd0 || d == 0)
            lead = 1'b0;
         if (lead)
            seg = SEG_BLANK;
`endif
         // Digits beyond NUM_DIGITS never match, so high pages show no DP.
         hex_nxt[d*8 +: 8] = {~((d == int'(page_idx)) & blink_ph), seg};
      end
   end

   // Stage p1 -> output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         hex_n <= '1;
      else
         hex_n <= hex_nxt;
   end

endmodule

// File: tb/tb_debug_hex_pager.sv
module tb_debug_hex_pager;

   localparam int ND   = 6;
   localparam int NP   = 4;
   localparam int DC   = 4;
   localparam int BC   = 8;
   localparam int DW   = NP * ND * 4;
   localparam int HW   = ND * 8;
   localparam int HMAX = 8192;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] page_data;
   logic          btn_n;
   logic          freeze;
   logic [HW-1:0] hex_n;
   logic [1:0]    page_idx;

   debug_hex_pager #(
      .NUM_DIGITS      (ND),
      .NUM_PAGES       (NP),
      .DEBOUNCE_CYCLES (DC),
      .BLINK_CYCLES    (BC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .page_data (page_data),
      .btn_n     (btn_n),
      .freeze    (freeze),
      .hex_n     (hex_n),
      .page_idx  (page_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Reference model: input history per clock edge since reset release.
   int            k;
   logic          bh [HMAX];
   logic          fh [HMAX];
   logic [DW-1:0] ph [HMAX];
   logic          acc;
   logic          armed;
   int            last_acc;
   int            page;
   logic [DW-1:0] snap;
   int            frun;
   logic [HW-1:0] exp_hex;
   int            exp_page;

   function automatic logic [6:0] seg_ref(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic hb(input int i);
      return (i < 1) ? 1'b1 : bh[i];
   endfunction

   function automatic logic hf(input int i);
      return (i < 1) ? 1'b0 : fh[i];
   endfunction

   function automatic logic [HW-1:0] render(input logic [DW-1:0] src, input int pg, input logic lit);
      logic [HW-1:0] r;
      logic [6:0]    s;
      logic [3:0]    n;
      logic          dp;
`ifdef DEBUG_HEX_LZB_EN
      int            msd;
      msd = 0;
      for (int d = 0; d < ND; d++)
         if (src[(pg*ND+d)*4 +: 4] != 4'd0) msd = d;
`endif
      r = '1;
      for (int d = 0; d < ND; d++) begin
         n = src[(pg*ND+d)*4 +: 4];
         s = seg_ref(n);
`ifdef DEBUG_HEX_LZB_EN
         if (d > msd) s = 7'h7F;
`endif
         dp = (d == pg && lit) ? 1'b0 : 1'b1;
         r[d*8 +: 8] = {dp, s};
      end
      return r;
   endfunction

   task automatic model_reset();
      k        = 0;
      acc      = 1'b1;
      armed    = 1'b0;
      last_acc = 0;
      page     = 0;
      snap     = '0;
      frun     = 0;
      exp_hex  = '1;
      exp_page = 0;
   endtask

   // Called at each rising edge with the inputs that were stable before it.
   task automatic model_edge();
      logic fz_now, fz_prev, lit, acc_b, arm_b, win;
      if (!reset_n) begin
         model_reset();
         return;
      end
      k++;
      bh[k] = btn_n;
      fh[k] = freeze;
      ph[k] = page_data;
      fz_now  = hf(k-2);
      fz_prev = hf(k-3);
      lit     = ((frun / BC) % 2) == 0;
      exp_hex = render((fz_now && fz_prev) ? snap : ph[k], page, lit);
      if (fz_now && !fz_prev) snap = ph[k];
      frun  = fz_now ? frun + 1 : 0;
      acc_b = acc;
      arm_b = armed;
      // a new key level is accepted after DC consecutive disagreeing samples
      win = (k - last_acc) >= DC;
      for (int j = k - DC + 1; j <= k; j++)
         if (hb(j-2) == acc_b) win = 1'b0;
      if (win) begin
         acc      = ~acc_b;
         last_acc = k;
         if (!acc && arm_b) page = (page + 1) % NP;
      end
      if (k >= 3 && hb(k-2) && acc_b) armed = 1'b1;
      exp_page = page;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic compare();
      if (!reset_n) begin
         check("cyc_hex_rst", 64'(hex_n), 64'({HW{1'b1}}));
         check("cyc_page_rst", 64'(page_idx), 64'd0);
      end else begin
         check("cyc_hex", 64'(hex_n), 64'(exp_hex));
         check("cyc_page", 64'(page_idx), 64'(exp_page));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Press held 10 cycles, then released 10 cycles; checks hex latency and page.
   task automatic press_key(input int want_page);
      logic [HW-1:0] old;
      int            n;
      old   = hex_n;
      n     = 0;
      btn_n = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (n == 0 && hex_n != old) n = i;
      end
      check("press_latency", 64'(n), 64'd7);
      btn_n = 1'b1;
      steps(10);
      check("press_page", 64'(page_idx), 64'(want_page));
   endtask

   initial begin
      int            prev_dp, last, nchg, moves, brun, frn;
      total     = 0;
      bad       = 0;
      reset_n   = 1'b0;
      btn_n     = 1'b1;
      freeze    = 1'b0;
      page_data = {24'h13579B, 24'h2468AC, 24'hABCDEF, 24'h123456};
      model_reset();

      // Reset and first display
      steps(3);
      check("reset_hex", 64'(hex_n), 64'({HW{1'b1}}));
      reset_n = 1'b1;
      step();
      check("release_hex", 64'(hex_n), 64'h0000_F9A4_B099_9202);
      check("release_page", 64'(page_idx), 64'd0);
      steps(5);

      // Four clean presses
      for (int i = 0; i < 4; i++) press_key((i + 1) % NP);

      // Short glitches
      for (int i = 0; i < 5; i++) begin
         btn_n = 1'b0;
         steps(3);
         btn_n = 1'b1;
         steps(2);
      end
      steps(10);
      check("glitch_page", 64'(page_idx), 64'd0);

      // Leading-zero page
      page_data[23:0] = 24'h000F00;
      steps(2);
`ifdef DEBUG_HEX_LZB_EN
      check("lzb_hex", 64'(hex_n), 64'h0000_FFFF_FF8E_C040);
`else
      check("lzb_hex", 64'(hex_n), 64'h0000_C0C0_C08E_C040);
`endif
      page_data[23:0] = 24'h123456;
      steps(2);

      // Freeze on page 1
      press_key(1);
      freeze = 1'b1;
      steps(4);
      page_data[47:24] = 24'h000000;
      steps(3);
      check("frozen_segs", 64'(hex_n & 48'h7F7F_7F7F_7F7F), 64'h0000_0803_4621_060E);
      prev_dp = int'(hex_n[15]);
      last    = -1;
      nchg    = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (int'(hex_n[15]) != prev_dp) begin
            if (last >= 0) check("blink_period", 64'(i - last), 64'd8);
            last    = i;
            prev_dp = int'(hex_n[15]);
            nchg++;
         end
      end
      check("blink_toggled", 64'(nchg >= 4), 64'd1);
      freeze = 1'b0;
      steps(4);
`ifdef DEBUG_HEX_LZB_EN
      check("unfrozen_hex", 64'(hex_n), 64'h0000_FFFF_FFFF_7FC0);
`else
      check("unfrozen_hex", 64'(hex_n), 64'h0000_C0C0_C0C0_40C0);
`endif
      moves = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (hex_n[15] != 1'b0) moves++;
      end
      check("dp_steady", 64'(moves), 64'd0);

      // Reset mid-debounce on page 2, key held through release
      press_key(2);
      btn_n = 1'b0;
      steps(2);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_hex", 64'(hex_n), 64'({HW{1'b1}}));
      check("async_rst_page", 64'(page_idx), 64'd0);
      steps(3);
      reset_n = 1'b1;
      steps(30);
      check("held_no_step", 64'(page_idx), 64'd0);
      btn_n = 1'b1;
      steps(10);
      press_key(1);

      // Randomized key, freeze and data activity
      brun = 0;
      frn  = 0;
      for (int i = 0; i < 800; i++) begin
         if (brun == 0) begin
            btn_n = ~btn_n;
            brun  = $urandom_range(1, 12);
         end
         brun--;
         if (frn == 0) begin
            freeze = ~freeze;
            frn    = $urandom_range(3, 60);
         end
         frn--;
         if ($urandom_range(0, 3) == 0) page_data = {$urandom, $urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
